// File: rtl/frame_bank_scheduler.sv
// frame_bank_scheduler
// Triple-buffer bank manager between the camera write path and the display
// read path (single i_p_clk domain). Banks are only exchanged at frame
// boundaries so the display never shows a torn frame, and per-side pixel
// offsets are converted into absolute frame-buffer addresses.
//
// Optional feature: define FB_FRAME_STATS_EN to build the saturating
// drop/repeat frame counters; otherwise both counter outputs are tied to 0.
//
// Ports:
//   i_p_clk          pixel clock, rising edge
//   i_rstn           synchronous active-low reset
//   i_wr_sof         writer start-of-frame pulse
//   i_wr_eof         writer end-of-frame pulse (last pixel written)
//   i_wr_offset      writer pixel index within frame
//   o_wr_addr        absolute write address (1-cycle latency)
//   i_rd_sof         display frame-boundary pulse
//   i_rd_offset      display pixel index within frame
//   o_rd_addr        absolute read address (1-cycle latency)
//   o_rd_frame_valid display bank holds a complete frame
//   o_wr_bank        current writer bank (0..2)
//   o_rd_bank        current reader bank (0..2)
//   o_ofs_err        sticky out-of-range offset flag
//   o_drop_cnt       dropped-frame count (saturating)
//   o_repeat_cnt     repeated-frame count (saturating)
module frame_bank_scheduler #(
  parameter int unsigned FRAME_WORDS = 307200,
  parameter int unsigned OFS_W       = 19,
  parameter int unsigned ADDR_W      = 20
) (
  input  logic              i_p_clk,
  input  logic              i_rstn,
  input  logic              i_wr_sof,
  input  logic              i_wr_eof,
  input  logic [OFS_W-1:0]  i_wr_offset,
  output logic [ADDR_W-1:0] o_wr_addr,
  input  logic              i_rd_sof,
  input  logic [OFS_W-1:0]  i_rd_offset,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_rd_frame_valid,
  output logic [1:0]        o_wr_bank,
  output logic [1:0]        o_rd_bank,
  output logic              o_ofs_err,
  output logic [15:0]       o_drop_cnt,
  output logic [15:0]       o_repeat_cnt
);

  localparam int unsigned CNT_W = 16;

  localparam logic [ADDR_W-1:0] BASE_1   = ADDR_W'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] BASE_2   = ADDR_W'(2 * FRAME_WORDS);
  localparam logic [ADDR_W-1:0] LAST_OFS = ADDR_W'(FRAME_WORDS - 1);
  localparam logic [OFS_W-1:0]  OFS_LIM  = OFS_W'(FRAME_WORDS);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_PRIMED = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] wr_bank, wr_bank_nxt;
  logic [1:0] rd_bank, rd_bank_nxt;
  logic [1:0] pd_bank, pd_bank_nxt;
  logic       pv, pv_nxt;
  logic       wr_in_frame, wr_in_frame_nxt;
  logic       eof_ok;

  // An eof only counts when it closes a frame whose sof we actually saw.
  assign eof_ok = i_wr_eof & wr_in_frame;

  // Bank base address from a constant mux.
  function automatic logic [ADDR_W-1:0] bank_base(input logic [1:0] b);
    case (b)
      2'd1:    bank_base = BASE_1;
      2'd2:    bank_base = BASE_2;
      default: bank_base = '0;
    endcase
  endfunction

  // Clamp the offset to the last word of the bank so it never spills over.
  function automatic logic [ADDR_W-1:0] clamp_ofs(input logic [OFS_W-1:0] ofs);
    if (ofs >= OFS_LIM) clamp_ofs = LAST_OFS;
    else                clamp_ofs = ADDR_W'(ofs);
  endfunction

  // State register.
  always_ff @(posedge i_p_clk) begin
    if (!i_rstn) state <= ST_EMPTY;
    else         state <= state_nxt;
  end

  // Next-state, bank rotation and writer-frame tracking.
  always_comb begin
    state_nxt       = state;
    wr_bank_nxt     = wr_bank;
    rd_bank_nxt     = rd_bank;
    pd_bank_nxt     = pd_bank;
    pv_nxt          = pv;
    wr_in_frame_nxt = wr_in_frame;

    if (eof_ok && i_rd_sof) begin
      // Finished frame goes straight to the reader; old reader bank is freed.
      wr_bank_nxt = pd_bank;
      rd_bank_nxt = wr_bank;
      pd_bank_nxt = rd_bank;
      pv_nxt      = 1'b0;
    end else if (eof_ok) begin
      wr_bank_nxt = pd_bank;
      pd_bank_nxt = wr_bank;
      pv_nxt      = 1'b1;
    end else if (i_rd_sof && pv) begin
      rd_bank_nxt = pd_bank;
      pd_bank_nxt = rd_bank;
      pv_nxt      = 1'b0;
    end

    // sof wins over a same-cycle eof: the eof closes the old frame first.
    if (i_wr_sof)    wr_in_frame_nxt = 1'b1;
    else if (eof_ok) wr_in_frame_nxt = 1'b0;

    case (state)
      ST_EMPTY: begin
        if (eof_ok && i_rd_sof) state_nxt = ST_RUN;
        else if (eof_ok)        state_nxt = ST_PRIMED;
      end
      ST_PRIMED: begin
        if (i_rd_sof) state_nxt = ST_RUN;
      end
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // Bank registers, flags and status outputs.
  always_ff @(posedge i_p_clk) begin
    if (!i_rstn) begin
      wr_bank          <= 2'd0;
      pd_bank          <= 2'd1;
      rd_bank          <= 2'd2;
      pv               <= 1'b0;
      wr_in_frame      <= 1'b0;
      o_rd_frame_valid <= 1'b0;
      o_ofs_err        <= 1'b0;
    end else begin
      wr_bank          <= wr_bank_nxt;
      pd_bank          <= pd_bank_nxt;
      rd_bank          <= rd_bank_nxt;
      pv               <= pv_nxt;
      wr_in_frame      <= wr_in_frame_nxt;
      o_rd_frame_valid <= (state_nxt == ST_RUN);
      if ((i_wr_offset >= OFS_LIM) || (i_rd_offset >= OFS_LIM)) o_ofs_err <= 1'b1;
    end
  end

  assign o_wr_bank = wr_bank;
  assign o_rd_bank = rd_bank;

  // Address generation uses the bank in effect when the offset is sampled.
  always_ff @(posedge i_p_clk) begin
    if (!i_rstn) begin
      o_wr_addr <= '0;
      o_rd_addr <= '0;
    end else begin
      o_wr_addr <= bank_base(wr_bank) + clamp_ofs(i_wr_offset);
      o_rd_addr <= bank_base(rd_bank) + clamp_ofs(i_rd_offset);
    end
  end

`ifdef FB_FRAME_STATS_EN
  logic drop_evt;
  logic repeat_evt;

  // A pending frame is lost whenever a new one lands on top of it.
  assign drop_evt   = eof_ok & pv;
  // Display restarts on the same bank with nothing new to show.
  assign repeat_evt = i_rd_sof & (state == ST_RUN) & ~pv & ~eof_ok;

  // Saturating frame statistics.
  always_ff @(posedge i_p_clk) begin
    if (!i_rstn) begin
      o_drop_cnt   <= '0;
      o_repeat_cnt <= '0;
    end else begin
      if (drop_evt && (o_drop_cnt != {CNT_W{1'b1}}))
        o_drop_cnt <= o_drop_cnt + CNT_W'(1);
      if (repeat_evt && (o_repeat_cnt != {CNT_W{1'b1}}))
        o_repeat_cnt <= o_repeat_cnt + CNT_W'(1);
    end
  end
`else
  assign o_drop_cnt   = CNT_W'(0);
  assign o_repeat_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Directed bench for frame_bank_scheduler: bank rotation, state machine,
// address generation/clamping and frame statistics (macro-aware).
module tb_frame_bank_scheduler;

  localparam int unsigned FRAME_WORDS = 307200;
  localparam int unsigned OFS_W       = 19;
  localparam int unsigned ADDR_W      = 20;

`ifdef FB_FRAME_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              i_p_clk = 1'b0;
  logic              i_rstn;
  logic              i_wr_sof, i_wr_eof, i_rd_sof;
  logic [OFS_W-1:0]  i_wr_offset, i_rd_offset;
  logic [ADDR_W-1:0] o_wr_addr, o_rd_addr;
  logic              o_rd_frame_valid, o_ofs_err;
  logic [1:0]        o_wr_bank, o_rd_bank;
  logic [15:0]       o_drop_cnt, o_repeat_cnt;

  int checks = 0;
  int errors = 0;

  frame_bank_scheduler #(
    .FRAME_WORDS(FRAME_WORDS), .OFS_W(OFS_W), .ADDR_W(ADDR_W)
  ) dut (
    .i_p_clk(i_p_clk), .i_rstn(i_rstn),
    .i_wr_sof(i_wr_sof), .i_wr_eof(i_wr_eof), .i_wr_offset(i_wr_offset),
    .o_wr_addr(o_wr_addr),
    .i_rd_sof(i_rd_sof), .i_rd_offset(i_rd_offset), .o_rd_addr(o_rd_addr),
    .o_rd_frame_valid(o_rd_frame_valid),
    .o_wr_bank(o_wr_bank), .o_rd_bank(o_rd_bank),
    .o_ofs_err(o_ofs_err),
    .o_drop_cnt(o_drop_cnt), .o_repeat_cnt(o_repeat_cnt)
  );

  always #5 i_p_clk = ~i_p_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock with the given pulses held for that cycle; sample #1 after edge.
  task automatic step(input logic ws, input logic we, input logic rs);
    i_wr_sof = ws; i_wr_eof = we; i_rd_sof = rs;
    @(posedge i_p_clk); #1;
    i_wr_sof = 1'b0; i_wr_eof = 1'b0; i_rd_sof = 1'b0;
  endtask

  task automatic do_reset();
    i_rstn = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);
    i_rstn = 1'b1;
  endtask

  function automatic logic [31:0] st(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  initial begin
    i_rstn = 1'b0; i_wr_sof = 1'b0; i_wr_eof = 1'b0; i_rd_sof = 1'b0;
    i_wr_offset = '0; i_rd_offset = '0;

    // Reset values (sampled while reset is held).
    i_rstn = 1'b0;
    step(0, 0, 0); step(0, 0, 0);
    chk("rst_wr_bank", 32'(o_wr_bank), 32'd0);
    chk("rst_rd_bank", 32'(o_rd_bank), 32'd2);
    chk("rst_valid",   32'(o_rd_frame_valid), 32'd0);
    chk("rst_wr_addr", 32'(o_wr_addr), 32'd0);
    chk("rst_rd_addr", 32'(o_rd_addr), 32'd0);
    chk("rst_ofs_err", 32'(o_ofs_err), 32'd0);
    chk("rst_drop",    32'(o_drop_cnt), 32'd0);
    chk("rst_repeat",  32'(o_repeat_cnt), 32'd0);
    i_rstn = 1'b1;

    // Address generation and clamping with W=0, R=2.
    i_rd_offset = 19'd1234; i_wr_offset = 19'd5;
    step(0, 0, 0);
    chk("rd_addr_1234", 32'(o_rd_addr), 32'd615634);
    chk("wr_addr_5",    32'(o_wr_addr), 32'd5);
    chk("ofs_err_ok",   32'(o_ofs_err), 32'd0);
    i_rd_offset = 19'd307200; i_wr_offset = 19'd524287;
    step(0, 0, 0);
    chk("rd_addr_clamp", 32'(o_rd_addr), 32'd921599);
    chk("wr_addr_clamp", 32'(o_wr_addr), 32'd307199);
    chk("ofs_err_set",   32'(o_ofs_err), 32'd1);
    i_rd_offset = 19'd0; i_wr_offset = 19'd0;
    step(0, 0, 0);
    chk("ofs_err_sticky", 32'(o_ofs_err), 32'd1);
    do_reset();
    chk("ofs_err_clear", 32'(o_ofs_err), 32'd0);

    // First frame: EMPTY -> PRIMED -> RUN.
    step(1, 0, 0);
    step(0, 1, 0);
    chk("f1_wr_bank", 32'(o_wr_bank), 32'd1);
    chk("f1_rd_bank", 32'(o_rd_bank), 32'd2);
    chk("f1_valid_primed", 32'(o_rd_frame_valid), 32'd0);
    step(0, 0, 1);
    chk("f1_rd_bank_sw", 32'(o_rd_bank), 32'd0);
    chk("f1_wr_bank_sw", 32'(o_wr_bank), 32'd1);
    chk("f1_valid_run",  32'(o_rd_frame_valid), 32'd1);
    chk("f1_repeat",     32'(o_repeat_cnt), 32'd0);
    i_rd_offset = 19'd10; i_wr_offset = 19'd7;
    step(0, 0, 0);
    chk("f1_rd_addr", 32'(o_rd_addr), 32'd10);
    chk("f1_wr_addr", 32'(o_wr_addr), 32'd307207);
    i_rd_offset = 19'd0; i_wr_offset = 19'd0;

    // Three display frames with nothing new: repeats, reader bank kept.
    step(0, 0, 1); step(0, 0, 0);
    step(0, 0, 1); step(0, 0, 0);
    step(0, 0, 1);
    chk("rep_rd_bank", 32'(o_rd_bank), 32'd0);
    chk("rep_cnt",     32'(o_repeat_cnt), st(3));

    // Two writer frames back to back, then display swap: first one dropped.
    step(1, 0, 0); step(0, 1, 0);
    chk("drop_wr_a", 32'(o_wr_bank), 32'd2);
    step(1, 0, 0); step(0, 1, 0);
    chk("drop_wr_b", 32'(o_wr_bank), 32'd1);
    chk("drop_cnt1", 32'(o_drop_cnt), st(1));
    step(0, 0, 1);
    chk("drop_rd_bank", 32'(o_rd_bank), 32'd2);
    chk("drop_wr_bank", 32'(o_wr_bank), 32'd1);
    chk("drop_repeat_hold", 32'(o_repeat_cnt), st(3));

    // Simultaneous eof + rd_sof from W=0,P=1,R=2,pv=1.
    do_reset();
    step(1, 0, 0); step(0, 1, 0);
    step(1, 0, 0); step(0, 1, 0);
    chk("sim_pre_wr", 32'(o_wr_bank), 32'd0);
    chk("sim_pre_rd", 32'(o_rd_bank), 32'd2);
    step(1, 0, 0);
    step(0, 1, 1);
    chk("sim_wr_bank", 32'(o_wr_bank), 32'd1);
    chk("sim_rd_bank", 32'(o_rd_bank), 32'd0);
    chk("sim_valid",   32'(o_rd_frame_valid), 32'd1);
    chk("sim_drop",    32'(o_drop_cnt), st(2));
    step(0, 0, 1);
    chk("sim_pv_clear_rd", 32'(o_rd_bank), 32'd0);
    chk("sim_repeat",      32'(o_repeat_cnt), st(1));

    // EMPTY -> RUN directly on simultaneous eof + rd_sof.
    do_reset();
    step(1, 0, 0);
    chk("direct_valid_pre", 32'(o_rd_frame_valid), 32'd0);
    step(0, 1, 1);
    chk("direct_wr_bank", 32'(o_wr_bank), 32'd1);
    chk("direct_rd_bank", 32'(o_rd_bank), 32'd0);
    chk("direct_valid",   32'(o_rd_frame_valid), 32'd1);
    chk("direct_drop",    32'(o_drop_cnt), 32'd0);

    // Reset mid-frame, then an orphan eof: ignored, still EMPTY.
    do_reset();
    step(1, 0, 0);
    do_reset();
    step(0, 1, 0);
    chk("orph_wr_bank", 32'(o_wr_bank), 32'd0);
    step(0, 0, 1);
    chk("orph_rd_bank", 32'(o_rd_bank), 32'd2);
    chk("orph_valid",   32'(o_rd_frame_valid), 32'd0);
    chk("orph_repeat",  32'(o_repeat_cnt), 32'd0);
    step(1, 0, 0); step(0, 1, 0);
    chk("orph_primed_valid", 32'(o_rd_frame_valid), 32'd0);
    step(0, 0, 1);
    chk("orph_run_valid", 32'(o_rd_frame_valid), 32'd1);
    chk("orph_run_rd",    32'(o_rd_bank), 32'd0);

    // Same-cycle sof+eof: eof closes frame, new frame opens, next eof valid.
    step(1, 0, 0);
    step(1, 1, 0);
    chk("sofeof_wr_a", 32'(o_wr_bank), 32'd2);
    step(0, 1, 0);
    chk("sofeof_wr_b", 32'(o_wr_bank), 32'd1);
    chk("sofeof_drop", 32'(o_drop_cnt), st(1));
    step(0, 1, 0);
    chk("sofeof_orphan", 32'(o_wr_bank), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
